log_arbiter: RTL and testbench

LOG_ARBITER -- requirements
Module: log_arbiter

---
 rtl/log_arbiter_pkg.sv | 7 +
 rtl/get_pow.sv | 13 +
 rtl/log_arbiter.sv | 84 ++++++++
 tb/tb_log_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/log_arbiter_pkg.sv
// log_arbiter_pkg: shared FSM state type and default sizing for log_arbiter
package log_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int NUM_W_DEF = 8;
  localparam int POW_W_DEF = $clog2(NUM_W_DEF);
endpackage

// File: rtl/get_pow.sv
// get_pow: log2 of an operand as the index of its highest set bit (0 for zero)
module get_pow import log_arbiter_pkg::*; #(
  parameter int NUM_W = NUM_W_DEF,
  parameter int POW_W = POW_W_DEF
) (
  input  logic [NUM_W-1:0] number,
  output logic [POW_W-1:0] pow
);
  always_comb begin
    pow = '0;
    for (int i = 0; i < NUM_W; i++) pow = number[i] ? POW_W'(i) : pow;
  end
endmodule

// File: rtl/log_arbiter.sv
// log_arbiter: round-robin share of one get_pow unit; LOG_ARBITER_ONEHOT_CHECK_EN enables the one-hot operand check
module log_arbiter import log_arbiter_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int NUM_W = NUM_W_DEF,
  parameter int POW_W = POW_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*NUM_W-1:0]     req_num,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [POW_W-1:0]           rsp_pow,
  output logic                       rsp_err,
  input  logic                       rsp_ready
);
  localparam int ID_W = $clog2(N_REQ);
  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [NUM_W-1:0] num_q;
  logic [POW_W-1:0] pow_raw;
  logic [POW_W-1:0] pow_chk;
  logic             err;
  // Scan offsets high to low so the smallest offset from p wins.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] v, input logic [ID_W-1:0] p);
    logic [N_REQ-1:0] g;
    logic [ID_W-1:0]  idx;
    g = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(p) + k) % N_REQ);
      if (v[idx]) begin
        g = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction
  assign req_ready = (state == IDLE && !rst) ? rr_pick(req_valid, rr_ptr) : '0;
  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++) gnt_id = req_ready[i] ? ID_W'(i) : gnt_id;
  end
  get_pow #(.NUM_W(NUM_W), .POW_W(POW_W)) u_get_pow (.number(num_q), .pow(pow_raw));
`ifdef LOG_ARBITER_ONEHOT_CHECK_EN
  assign err     = (num_q == '0) || ((num_q & (num_q - NUM_W'(1))) != '0);
  assign pow_chk = err ? '0 : pow_raw;
`else
  assign err     = 1'b0;
  assign pow_chk = pow_raw;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      num_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_pow   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          num_q  <= req_num[gnt_id*NUM_W +: NUM_W];
          rsp_id <= gnt_id;
          rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
          state  <= CALC;
        end
        CALC: begin
          rsp_pow   <= pow_chk;
          rsp_err   <= err;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_log_arbiter.sv
// tb_log_arbiter: directed self-checking bench for log_arbiter
module tb_log_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_num;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [2:0]  rsp_pow;
  logic        rsp_err;
  logic        rsp_ready;
  int total = 0;
  int bad = 0;
  log_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_num(req_num),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_pow(rsp_pow), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic run_req(input int id, input logic [7:0] num, output bit got);
    req_num[id*8 +: 8] = num;
    req_valid = 4'b0001 << id;
    tick;
    req_valid = 4'b0000;
    for (int i = 0; i < 8 && !rsp_valid; i++) tick;
    got = rsp_valid;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_num = 32'h0;
    rsp_ready = 1'b0;
    tick;
    tick;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (rsp_pow !== 3'd0) begin bad++; $display("FAIL reset_rsp_pow got=%0d exp=0", rsp_pow); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    req_valid = 4'b0000;
    rst = 1'b0;
    tick;
  endtask
  task automatic test_single;
    req_num[7:0] = 8'h40;
    req_valid = 4'b0001;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick;
    req_valid = 4'b0000;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_calc_valid got=%b exp=0", rsp_valid); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_calc_ready got=%b exp=0000", req_ready); end
    tick;
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL single_rsp_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (rsp_pow !== 3'd6) begin bad++; $display("FAIL single_rsp_pow got=%0d exp=6", rsp_pow); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL single_rsp_err got=%b exp=0", rsp_err); end
    rsp_ready = 1'b1;
    tick;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask
  task automatic test_round_robin;
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] exp_pow [5] = '{3'd3, 3'd0, 3'd7, 3'd1, 3'd3};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req_num = {8'h02, 8'h80, 8'h01, 8'h08};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < 8 && !rsp_valid; i++) tick;
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_timeout[%0d] got=%b exp=1", n, rsp_valid); end
      total++; if (rsp_id !== exp_id[n]) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", n, rsp_id, exp_id[n]); end
      total++; if (rsp_pow !== exp_pow[n]) begin bad++; $display("FAIL rr_pow[%0d] got=%0d exp=%0d", n, rsp_pow, exp_pow[n]); end
      tick;
    end
    req_valid = 4'b0000;
    for (int i = 0; i < 8 && rsp_valid; i++) tick;
    rsp_ready = 1'b0;
    tick;
  endtask
  task automatic test_backpressure;
    req_valid = 4'b0100;
    tick;
    req_valid = 4'b1111;
    for (int i = 0; i < 8 && !rsp_valid; i++) tick;
    for (int c = 0; c < 5; c++) begin
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, rsp_valid); end
      total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL bp_id[%0d] got=%0d exp=2", c, rsp_id); end
      total++; if (rsp_pow !== 3'd7) begin bad++; $display("FAIL bp_pow[%0d] got=%0d exp=7", c, rsp_pow); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_release_ready got=%b exp=0000", req_ready); end
    tick;
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); end
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_next_grant got=%b exp=1000", req_ready); end
    req_valid = 4'b0000;
    tick;
  endtask
  task automatic test_reset_mid_calc;
    req_num[31:24] = 8'h10;
    req_valid = 4'b1000;
    tick;
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready_low got=%b exp=0000", req_ready); end
    tick;
    rst = 1'b0;
    req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp[%0d] got=%b exp=0", c, rsp_valid); end
      tick;
    end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rst_next_grant got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
    tick;
  endtask
  task automatic test_onehot_check;
    bit got;
    logic exp_err;
`ifdef LOG_ARBITER_ONEHOT_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_req(1, 8'h41, got);
    total++; if (!got) begin bad++; $display("FAIL oh_41_timeout got=0 exp=1"); end
    total++; if (rsp_err !== exp_err) begin bad++; $display("FAIL oh_41_err got=%b exp=%b", rsp_err, exp_err); end
    if (exp_err) begin
      total++; if (rsp_pow !== 3'd0) begin bad++; $display("FAIL oh_41_pow got=%0d exp=0", rsp_pow); end
    end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    run_req(2, 8'h00, got);
    total++; if (!got) begin bad++; $display("FAIL oh_00_timeout got=0 exp=1"); end
    total++; if (rsp_err !== exp_err) begin bad++; $display("FAIL oh_00_err got=%b exp=%b", rsp_err, exp_err); end
    total++; if (rsp_pow !== 3'd0) begin bad++; $display("FAIL oh_00_pow got=%0d exp=0", rsp_pow); end
    total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL oh_00_id got=%0d exp=2", rsp_id); end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    run_req(3, 8'h20, got);
    total++; if (!got) begin bad++; $display("FAIL oh_20_timeout got=0 exp=1"); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL oh_20_err got=%b exp=0", rsp_err); end
    total++; if (rsp_pow !== 3'd5) begin bad++; $display("FAIL oh_20_pow got=%0d exp=5", rsp_pow); end
    rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_reset_mid_calc;
    test_onehot_check;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
